// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters. A round-robin
// arbiter picks a requester in IDLE, the winner's op/operands are latched and
// presented to the ALU for one EXEC cycle, the ALU result is captured, and the
// result is held on the owner's response channel (RESP) until it is accepted.
// Only one transaction is in flight at a time.
//
// Parameters:
//   WIDTH  operand/result width
//   OPW    ALU op code width (op codes are forwarded unmodified)
//   CNT_W  grant counter width (used only with ALU_ARB_STATS_EN)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req{0,1}_valid/_ready       request handshake per requester
//   req{0,1}_op/_a/_b           request payload per requester
//   rsp{0,1}_valid/_ready       response handshake per requester
//   rsp{0,1}_data               response data per requester
//   alu_op/alu_a/alu_b          registered drive to the shared ALU
//   alu_result                  combinational result from the shared ALU
//   grant_cnt0/grant_cnt1       saturating grant counters (ALU_ARB_STATS_EN only)
//
// Configuration macro: ALU_ARB_STATS_EN
//   defined   -> grant_cnt0/grant_cnt1 ports and saturating counters present
//   undefined -> no counter ports or logic
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // response 0
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  // response 1
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  // shared ALU
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             prio;       // requester favoured when both are valid
  logic             owner;      // requester that owns the in-flight transaction
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res0_q;     // held result for requester 0
  logic [WIDTH-1:0] res1_q;     // held result for requester 1

  logic             grant_any;
  logic             grant_sel;

  // Arbitration: only in IDLE and never while reset is asserted, so a ready
  // pulse always corresponds to an actual grant on the next edge.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (!rst && state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_sel = prio;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_sel;
  assign req1_ready = grant_any &&  grant_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            op_q  <= grant_sel ? req1_op : req0_op;
            a_q   <= grant_sel ? req1_a  : req0_a;
            b_q   <= grant_sel ? req1_b  : req0_b;
            owner <= grant_sel;
            prio  <= ~grant_sel;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (owner) res1_q <= alu_result;
          else       res0_q <= alu_result;
          state <= S_RESP;
        end
        S_RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU drive comes straight from the latched registers, so it is stable for
  // the whole EXEC cycle and keeps its last value while idle.
  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  assign rsp0_valid = (state == S_RESP) && !owner;
  assign rsp1_valid = (state == S_RESP) &&  owner;
  assign rsp0_data  = res0_q;
  assign rsp1_data  = res1_q;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_ONE;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Small external ALU: add, sub, xor, signed/unsigned less-than; other codes -> 0
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0111: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b1000: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1011: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
  endtask

  task automatic drive0(input logic v, input logic [OPW-1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [OPW-1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    do_reset();

    // reset state
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chkw("rst_rsp0_data", rsp0_data, 32'h0);
    chkw("rst_alu_a", alu_a, 32'h0);
    chkw("rst_alu_op", {28'd0, alu_op}, 32'h0);

    // 1: single add, latency 2 cycles to response
    drive0(1'b1, 4'b0000, 32'd5, 32'd7);
    #1;
    chk1("t1_req0_ready", req0_ready, 1'b1);
    chk1("t1_req1_ready", req1_ready, 1'b0);
    tick();                                   // EXEC
    drive0(1'b0, '0, '0, '0);
    #1;
    chk1("t1_exec_ready", req0_ready, 1'b0);
    chkw("t1_alu_a", alu_a, 32'd5);
    chkw("t1_alu_b", alu_b, 32'd7);
    chk1("t1_exec_rsp0_valid", rsp0_valid, 1'b0);
    tick();                                   // RESP
    chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
    chkw("t1_rsp0_data", rsp0_data, 32'd12);
    chk1("t1_rsp1_valid", rsp1_valid, 1'b0);
    rsp0_ready = 1'b1;
    tick();                                   // IDLE
    rsp0_ready = 1'b0;
    chk1("t1_idle_rsp0_valid", rsp0_valid, 1'b0);
    chkw("t1_idle_data_held", rsp0_data, 32'd12);

    // 2: simultaneous requests after reset, req0 first
    do_reset();
    drive0(1'b1, 4'b0111, 32'd10, 32'd3);
    drive1(1'b1, 4'b0010, 32'hF0, 32'hFF);
    #1;
    chk1("t2_req0_ready", req0_ready, 1'b1);
    chk1("t2_req1_ready", req1_ready, 1'b0);
    tick();                                   // EXEC req0
    drive0(1'b0, '0, '0, '0);
    #1;
    chk1("t2_exec_req1_ready", req1_ready, 1'b0);
    tick();                                   // RESP req0
    chk1("t2_rsp0_valid", rsp0_valid, 1'b1);
    chkw("t2_rsp0_data", rsp0_data, 32'd7);
    chk1("t2_rsp1_quiet", rsp1_valid, 1'b0);
    chk1("t2_resp_req1_ready", req1_ready, 1'b0);
    rsp0_ready = 1'b1;
    tick();                                   // IDLE
    rsp0_ready = 1'b0;
    chk1("t2_idle_req1_ready", req1_ready, 1'b1);
    tick();                                   // EXEC req1
    drive1(1'b0, '0, '0, '0);
    #1;
    chkw("t2_alu_a", alu_a, 32'hF0);
    chkw("t2_alu_op", {28'd0, alu_op}, 32'h2);
    tick();                                   // RESP req1
    chk1("t2_rsp1_valid", rsp1_valid, 1'b1);
    chkw("t2_rsp1_data", rsp1_data, 32'h0F);
    chk1("t2_rsp0_quiet", rsp0_valid, 1'b0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // alternation with both requesters saturating (last grant was 1 -> 0 next)
    drive0(1'b1, 4'b0000, 32'd1, 32'd1);
    drive1(1'b1, 4'b0000, 32'd2, 32'd2);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("alt%0d_req0_ready", i), req0_ready, (i % 2) == 0);
      chk1($sformatf("alt%0d_req1_ready", i), req1_ready, (i % 2) == 1);
      tick();
      tick();
      chk1($sformatf("alt%0d_rsp0_valid", i), rsp0_valid, (i % 2) == 0);
      chk1($sformatf("alt%0d_rsp1_valid", i), rsp1_valid, (i % 2) == 1);
      tick();
    end
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // 3: signed vs unsigned compare through requester 1
    drive1(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk1("t3a_req1_ready", req1_ready, 1'b1);
    tick();
    drive1(1'b0, '0, '0, '0);
    tick();
    chk1("t3a_rsp1_valid", rsp1_valid, 1'b1);
    chkw("t3a_rsp1_data", rsp1_data, 32'd1);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    drive1(1'b1, 4'b1011, 32'hFFFF_FFFF, 32'd1);
    tick();
    drive1(1'b0, '0, '0, '0);
    #1;
    chkw("t3b_alu_op", {28'd0, alu_op}, 32'hB);
    tick();
    chkw("t3b_rsp1_data", rsp1_data, 32'd0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // 4: response back-pressure holds data; waiting requester sees no ready
    drive0(1'b1, 4'b0000, 32'd1, 32'd2);
    tick();                                   // EXEC
    drive0(1'b0, '0, '0, '0);
    drive1(1'b1, 4'b0000, 32'h100, 32'h1);
    tick();                                   // RESP
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("t4_hold%0d_valid", i), rsp0_valid, 1'b1);
      chkw($sformatf("t4_hold%0d_data", i), rsp0_data, 32'd3);
      chk1($sformatf("t4_hold%0d_req1_ready", i), req1_ready, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk1("t4_release_req1_ready", req1_ready, 1'b0);
    tick();                                   // IDLE
    rsp0_ready = 1'b0;
    chk1("t4_idle_req1_ready", req1_ready, 1'b1);
    tick();
    drive1(1'b0, '0, '0, '0);
    tick();
    chk1("t4_rsp1_valid", rsp1_valid, 1'b1);
    chkw("t4_rsp1_data", rsp1_data, 32'h101);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // 5: reset during EXEC discards transaction and restores prio=0
    drive0(1'b1, 4'b0000, 32'd9, 32'd9);
    tick();                                   // EXEC req0, prio now 1
    drive0(1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t5_rsp0_valid", rsp0_valid, 1'b0);
    chkw("t5_alu_a", alu_a, 32'h0);
    chkw("t5_rsp0_data", rsp0_data, 32'h0);
    tick();
    chk1("t5_later_rsp0_valid", rsp0_valid, 1'b0);
    chk1("t5_later_rsp1_valid", rsp1_valid, 1'b0);
    drive0(1'b1, 4'b0000, 32'd4, 32'd4);
    drive1(1'b1, 4'b0000, 32'd6, 32'd6);
    #1;
    chk1("t5_req0_ready", req0_ready, 1'b1);
    chk1("t5_req1_ready", req1_ready, 1'b0);
    tick();
    drive0(1'b0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0);
    tick();
    chkw("t5_rsp0_data", rsp0_data, 32'd8);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
    // 6: five grants to req0 saturate a 2-bit counter at 3
    do_reset();
    chkw("t6_rst_cnt0", {30'd0, grant_cnt0}, 32'd0);
    drive0(1'b1, 4'b0000, 32'd1, 32'd1);
    rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) chkw("t6_cnt0_first", {30'd0, grant_cnt0}, 32'd1);
      tick();
      tick();
    end
    drive0(1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    tick();
    chkw("t6_cnt0_sat", {30'd0, grant_cnt0}, 32'd3);
    chkw("t6_cnt1", {30'd0, grant_cnt1}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
